// File: rtl/maze_port_arbiter.sv
// Shares one maze memory port between two walker requesters (cell read / visited-mark write).
// Round-robin by default; define MAZE_ARB_FIXED_PRIO_EN for fixed priority with requester 0 winning ties.
module maze_port_arbiter #(
  parameter int maze_width = 6,
  parameter int cnt_width  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic [maze_width-1:0] row0,
  input  logic [maze_width-1:0] col0,
  input  logic [maze_width-1:0] row1,
  input  logic [maze_width-1:0] col1,
  input  logic                  wr0,
  input  logic                  wr1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic                  rdata,
  output logic [maze_width-1:0] row,
  output logic [maze_width-1:0] col,
  output logic                  maze_oe,
  output logic                  maze_we,
  input  logic                  maze_in,
  output logic [cnt_width-1:0]  grant_cnt0,
  output logic [cnt_width-1:0]  grant_cnt1,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_last, r_wr, r_busy, r_rdata;
  logic                  r_gnt0, r_gnt1, r_rv0, r_rv1, r_oe, r_we;
  logic [maze_width-1:0] r_row, r_col;
  logic [cnt_width-1:0]  r_cnt0, r_cnt1;

  logic                  w_any, w_win, w_wr_sel, w_take;
  logic [maze_width-1:0] w_row_sel, w_col_sel;
  logic                  w_gnt0_nxt, w_gnt1_nxt, w_rv0_nxt, w_rv1_nxt, w_oe_nxt, w_we_nxt;

  always_comb begin
    w_any = req0 | req1;
`ifdef MAZE_ARB_FIXED_PRIO_EN
    w_win = ~req0;
`else
    // On a tie the requester that did not win last time goes next.
    w_win = (req0 & req1) ? ~r_last : req1;
`endif
    w_wr_sel  = w_win ? wr1  : wr0;
    w_row_sel = w_win ? row1 : row0;
    w_col_sel = w_win ? col1 : col0;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_gnt0_nxt  = 1'b0;
    w_gnt1_nxt  = 1'b0;
    w_rv0_nxt   = 1'b0;
    w_rv1_nxt   = 1'b0;
    w_oe_nxt    = 1'b0;
    w_we_nxt    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_take      = 1'b1;
          w_state_nxt = ISSUE;
          w_gnt0_nxt  = ~w_win;
          w_gnt1_nxt  = w_win;
          w_oe_nxt    = ~w_wr_sel;
          w_we_nxt    = w_wr_sel;
        end
      end
      ISSUE: w_state_nxt = r_wr ? IDLE : RESP;
      RESP: begin
        w_state_nxt = IDLE;
        w_rv0_nxt   = ~r_last;
        w_rv1_nxt   = r_last;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_wr    <= 1'b0;
      r_busy  <= 1'b0;
      r_rdata <= 1'b0;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_rv0   <= 1'b0;
      r_rv1   <= 1'b0;
      r_oe    <= 1'b0;
      r_we    <= 1'b0;
      r_row   <= '0;
      r_col   <= '0;
      r_cnt0  <= '0;
      r_cnt1  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != IDLE);
      r_gnt0  <= w_gnt0_nxt;
      r_gnt1  <= w_gnt1_nxt;
      r_rv0   <= w_rv0_nxt;
      r_rv1   <= w_rv1_nxt;
      r_oe    <= w_oe_nxt;
      r_we    <= w_we_nxt;
      // Counters advance on the same edge that raises gnt, so they line up with it.
      if (w_take) begin
        r_last <= w_win;
        r_wr   <= w_wr_sel;
        r_row  <= w_row_sel;
        r_col  <= w_col_sel;
        if (!w_win && (r_cnt0 != {cnt_width{1'b1}}))
          r_cnt0 <= r_cnt0 + cnt_width'(1);
        if (w_win && (r_cnt1 != {cnt_width{1'b1}}))
          r_cnt1 <= r_cnt1 + cnt_width'(1);
      end
      if (r_state == RESP)
        r_rdata <= maze_in;
    end
  end

  assign gnt0       = r_gnt0;
  assign gnt1       = r_gnt1;
  assign rvalid0    = r_rv0;
  assign rvalid1    = r_rv1;
  assign rdata      = r_rdata;
  assign row        = r_row;
  assign col        = r_col;
  assign maze_oe    = r_oe;
  assign maze_we    = r_we;
  assign grant_cnt0 = r_cnt0;
  assign grant_cnt1 = r_cnt1;
  assign busy       = r_busy;
endmodule

// File: tb/tb_maze_port_arbiter.sv
// Randomised bench for maze_port_arbiter: transaction-level reference schedule plus a behavioural maze memory.
module tb_maze_port_arbiter;
  localparam int MW   = 6;
  localparam int NCYC = 5000;
  localparam int NE   = NCYC + 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0 = 1'b0, req1 = 1'b0, wr0 = 1'b0, wr1 = 1'b0, maze_in = 1'b0;
  logic [MW-1:0] row0 = '0, col0 = '0, row1 = '0, col1 = '0;
  logic gnt0, gnt1, rvalid0, rvalid1, rdata, maze_oe, maze_we, busy;
  logic [MW-1:0] row, col;
  logic [7:0] grant_cnt0, grant_cnt1;

  logic s_gnt0, s_gnt1, s_rv0, s_rv1, s_rdata, s_oe, s_we, s_busy;
  logic [MW-1:0] s_row, s_col;
  logic [1:0] s_cnt0, s_cnt1;

  maze_port_arbiter #(.maze_width(MW), .cnt_width(8)) u_dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .row0(row0), .col0(col0), .row1(row1), .col1(col1), .wr0(wr0), .wr1(wr1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
    .row(row), .col(col), .maze_oe(maze_oe), .maze_we(maze_we), .maze_in(maze_in),
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .busy(busy));

  maze_port_arbiter #(.maze_width(MW), .cnt_width(2)) u_sat (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .row0(row0), .col0(col0), .row1(row1), .col1(col1), .wr0(wr0), .wr1(wr1),
    .gnt0(s_gnt0), .gnt1(s_gnt1), .rvalid0(s_rv0), .rvalid1(s_rv1), .rdata(s_rdata),
    .row(s_row), .col(s_col), .maze_oe(s_oe), .maze_we(s_we), .maze_in(maze_in),
    .grant_cnt0(s_cnt0), .grant_cnt1(s_cnt1), .busy(s_busy));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  typedef struct {int t; bit wr; int r; int c;} op_t;
  op_t scr[2][$];

  // Expected per-cycle pulses and hold-value update events.
  bit e_gnt[2][NE], e_rv[2][NE], e_inc[2][NE];
  bit e_oe[NE], e_we[NE], e_busy[NE], e_rst[NE], e_rc[NE], e_rd_set[NE], e_rd[NE];
  int e_row[NE], e_col[NE];

  bit dev_mem [64][64];
  bit shadow  [64][64];

  function automatic int pick(bit a, bit b, int last);
    if (a && b) begin
`ifdef MAZE_ARB_FIXED_PRIO_EN
      return 0;
`else
      return 1 - last;
`endif
    end
    return a ? 0 : 1;
  endfunction

  task automatic add_op(input int k, input int t, input bit wr, input int r, input int c);
    op_t o;
    o.t = t; o.wr = wr; o.r = r; o.c = c;
    scr[k].push_back(o);
  endtask

  initial begin
    bit pend[2];
    bit p_wr[2];
    int p_r[2], p_c[2];
    int free_at, m_last, resp_at, win;
    int cur_row, cur_col, cur_rd, cur_n0, cur_n1;
    bit armed, rst_c, p_oe;
    logic [MW-1:0] p_row, p_col;

    for (int i = 0; i < 64; i++)
      for (int j = 0; j < 64; j++) begin
        dev_mem[i][j] = 1'($urandom_range(0, 1));
        shadow[i][j]  = dev_mem[i][j];
      end
    dev_mem[5][7] = 1'b1; shadow[5][7] = 1'b1;
    dev_mem[0][63] = 1'b0; shadow[0][63] = 1'b0;

    add_op(0, 5, 1'b0, 5, 7);
    add_op(1, 12, 1'b1, 0, 63);
    for (int i = 0; i < 3; i++) begin
      add_op(0, 20, 1'b0, i, 2 * i);
      add_op(1, 20, 1'b0, 0, 63);
    end
    add_op(0, 45, 1'b0, 9, 9);
    for (int i = 0; i < 5; i++) add_op(0, 55, 1'b1, 30 + i, 1);

    pend = '{0, 0}; p_wr = '{0, 0}; p_r = '{0, 0}; p_c = '{0, 0};
    free_at = 0; m_last = 1; resp_at = -1; armed = 1'b1; p_oe = 1'b0;
    p_row = '0; p_col = '0;
    cur_row = 0; cur_col = 0; cur_rd = 0; cur_n0 = 0; cur_n1 = 0;

    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      cyc = c;
      if (c >= 1) begin
        if (e_rst[c]) begin
          cur_row = 0; cur_col = 0; cur_rd = 0; cur_n0 = 0; cur_n1 = 0;
        end
        if (e_rc[c]) begin cur_row = e_row[c]; cur_col = e_col[c]; end
        if (e_rd_set[c]) cur_rd = int'(e_rd[c]);
        if (e_inc[0][c]) cur_n0++;
        if (e_inc[1][c]) cur_n1++;
        check_eq("gnt0", 32'(gnt0), 32'(e_gnt[0][c]));
        check_eq("gnt1", 32'(gnt1), 32'(e_gnt[1][c]));
        check_eq("rvalid0", 32'(rvalid0), 32'(e_rv[0][c]));
        check_eq("rvalid1", 32'(rvalid1), 32'(e_rv[1][c]));
        check_eq("maze_oe", 32'(maze_oe), 32'(e_oe[c]));
        check_eq("maze_we", 32'(maze_we), 32'(e_we[c]));
        check_eq("busy", 32'(busy), 32'(e_busy[c]));
        check_eq("row", 32'(row), cur_row);
        check_eq("col", 32'(col), cur_col);
        check_eq("rdata", 32'(rdata), cur_rd);
        check_eq("cnt0", 32'(grant_cnt0), (cur_n0 > 255) ? 255 : cur_n0);
        check_eq("cnt1", 32'(grant_cnt1), (cur_n1 > 255) ? 255 : cur_n1);
        check_eq("sat_cnt0", 32'(s_cnt0), (cur_n0 > 3) ? 3 : cur_n0);
        check_eq("sat_cnt1", 32'(s_cnt1), (cur_n1 > 3) ? 3 : cur_n1);
      end

      // Maze memory: read data appears the cycle after maze_oe; writes mark the cell.
      maze_in = p_oe ? dev_mem[p_row][p_col] : 1'($urandom_range(0, 1));
      p_oe = maze_oe; p_row = row; p_col = col;
      if (maze_we === 1'b1) dev_mem[row][col] = 1'b1;

      rst_c = (c < 3) || (c >= 1000 && c < 1400 && $urandom_range(0, 99) == 0);
      if (armed && c >= 45 && c == resp_at) begin
        rst_c = 1'b1;
        armed = 1'b0;
      end

      for (int k = 0; k < 2; k++) begin
        if (!pend[k]) begin
          if (scr[k].size() > 0 && c >= scr[k][0].t) begin
            op_t o;
            o = scr[k].pop_front();
            pend[k] = 1'b1; p_wr[k] = o.wr; p_r[k] = o.r; p_c[k] = o.c;
          end else begin
            p_wr[k] = 1'($urandom_range(0, 1));
            p_r[k]  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 3));
            p_c[k]  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 3));
            if (c >= 80 && scr[k].size() == 0 && $urandom_range(0, 99) < 60) begin
              pend[k] = 1'b1;
              p_wr[k] = ($urandom_range(0, 2) == 0);
            end
          end
        end
      end
      rst  = rst_c;
      req0 = pend[0]; wr0 = p_wr[0]; row0 = MW'(p_r[0]); col0 = MW'(p_c[0]);
      req1 = pend[1]; wr1 = p_wr[1]; row1 = MW'(p_r[1]); col1 = MW'(p_c[1]);

      if (rst_c) begin
        for (int d = 1; d <= 4; d++) begin
          for (int k = 0; k < 2; k++) begin
            e_gnt[k][c+d] = 0; e_rv[k][c+d] = 0; e_inc[k][c+d] = 0;
          end
          e_oe[c+d] = 0; e_we[c+d] = 0; e_busy[c+d] = 0; e_rc[c+d] = 0; e_rd_set[c+d] = 0;
        end
        e_rst[c+1] = 1'b1;
        free_at = c + 1;
        m_last = 1;
      end else if (c >= free_at && (pend[0] || pend[1])) begin
        win = pick(pend[0], pend[1], m_last);
        m_last = win;
        e_gnt[win][c+1] = 1'b1;
        e_inc[win][c+1] = 1'b1;
        e_rc[c+1] = 1'b1; e_row[c+1] = p_r[win]; e_col[c+1] = p_c[win];
        e_oe[c+1] = !p_wr[win];
        e_we[c+1] = p_wr[win];
        e_busy[c+1] = 1'b1;
        if (p_wr[win]) begin
          shadow[p_r[win]][p_c[win]] = 1'b1;
          free_at = c + 2;
        end else begin
          e_busy[c+2] = 1'b1;
          e_rv[win][c+3] = 1'b1;
          e_rd_set[c+3] = 1'b1;
          e_rd[c+3] = shadow[p_r[win]][p_c[win]];
          free_at = c + 3;
          resp_at = c + 2;
        end
        pend[win] = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/maze_port_arbiter.md
# maze_port_arbiter

Shares the single maze memory port (row/col select, synchronous read and write enables, `maze_in` read data) between two maze-walker requesters. Each requester posts a read or visited-mark write with a req/gnt handshake. The arbiter serialises accesses, drives the maze port for exactly one cycle per access, and routes read data back with a valid pulse. It sits between the solver instances and the maze memory, and keeps per-requester grant counters for debug.

## Interface
Parameters:
- `maze_width`, 6, row/col index width
- `cnt_width`, 8, width of each grant counter

Ports:
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  synchronous active-high reset
- `req0`, `req1`  in  1  access request; held with address/op until matching gnt
- `row0`, `col0`, `row1`, `col1`  in  maze_width  requested cell
- `wr0`, `wr1`  in  1  1 = write (mark cell), 0 = read
- `gnt0`, `gnt1`  out  1  one-cycle pulse: request accepted and issued this cycle
- `rvalid0`, `rvalid1`  out  1  one-cycle pulse: `rdata` valid for that requester
- `rdata`  out  1  captured `maze_in` of the last read
- `row`, `col`  out  maze_width  maze port cell select
- `maze_oe`  out  1  maze read enable, synchronous
- `maze_we`  out  1  maze write enable, synchronous
- `maze_in`  in  1  maze read data, valid the cycle after `maze_oe`
- `grant_cnt0`, `grant_cnt1`  out  cnt_width  saturating grant counters
- `busy`  out  1  state != IDLE

## Operation
- All outputs are registered.
- FSM states:
  - IDLE: if any req is high, select a winner, latch its row/col/wr, set `last` = winner, go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: drive `row`/`col`. Assert `maze_we` = wr and `maze_oe` = !wr for this cycle only. Pulse gnt of the winner. Increment its counter.
    - If wr: go to IDLE.
    - If read: go to RESP.
  - RESP: capture `maze_in` into `rdata`. Pulse rvalid of the winner in the next cycle. Go to IDLE.
- Arbitration is round-robin between the two requesters.
  - Only one req high: that requester wins.
  - Both high: the requester that is not `last` wins.
  - `last` resets to 1, so requester 0 wins the first tie.
- `row`/`col` hold their last issued value outside ISSUE.
- `maze_oe` and `maze_we` are 0 outside ISSUE and are never both 1.
- A requester must keep req, row, col and wr stable from assertion until its gnt.
- Dropping req before gnt is allowed only in IDLE. The arbiter samples inputs only in IDLE.
- Counters saturate at 2^cnt_width-1 and do not wrap.
- `rdata` holds its value until the next RESP.

## Timing
- Reset values:
  - `gnt*`, `rvalid*`, `maze_oe`, `maze_we`, `busy`, `rdata` = 0
  - `row`, `col` = 0
  - counters = 0
  - state = IDLE, `last` = 1
- Read: req sampled in IDLE at cycle T.
  - Cycle T+1: gnt + `maze_oe`.
  - Cycle T+2: `maze_in` captured.
  - Cycle T+3: rvalid + `rdata`.
- Write: req sampled at T. Cycle T+1: gnt + `maze_we`. Cycle T+2: IDLE again.
- Throughput is one read per 3 cycles or one write per 2 cycles.
- rvalid in IDLE coincides with sampling of the next request. Both can happen in the same cycle.
- rst high in any state: next cycle is IDLE with reset values. A pending read is dropped with no rvalid, and no gnt is issued.
- rst has priority over every other input.

## Configuration
- `MAZE_ARB_FIXED_PRIO_EN`
  - Defined: fixed priority. Requester 0 always wins when both requesters are high. `last` is still updated but ignored.
  - Undefined (default): round-robin as described in Operation.

## Test plan
- After reset, `req0`=1, `wr0`=0, `row0`=5, `col0`=7, `maze_in`=1 driven in the cycle after `maze_oe`:
  - `gnt0` and `maze_oe` at T+1, with `row`=5, `col`=7.
  - `rvalid0` at T+3 with `rdata`=1.
  - `grant_cnt0`=1.
- `req1`=1, `wr1`=1, `row1`=0, `col1`=63: `maze_we` is high exactly one cycle with `row`=0, `col`=63, together with `gnt1`. `busy` returns to 0 two cycles after the request.
- Both requesters read continuously for 6 grants:
  - Default build: grants alternate 0,1,0,1,0,1.
  - With `MAZE_ARB_FIXED_PRIO_EN`: all 6 grants go to requester 0.
- rst asserted in RESP of a read: no rvalid. Next cycle has all outputs at their reset values and counters = 0.
- `cnt_width`=2, 5 writes from requester 0: `grant_cnt0` stops at 3.
- Back-to-back reads: the second req is sampled in the same cycle as the first rvalid, and its gnt follows one cycle later.
